// File: rtl/wb_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_pkg
// Description : Shared types and default widths for the 2:1 Wishbone arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package wb_arb_pkg;

    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_TIMEOUT_CYCLES = 255;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2,
        ABORT  = 2'd3
    } arb_state_t;

endpackage : wb_arb_pkg
`default_nettype wire

// File: rtl/wb_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : wb_arb_watchdog
// Description : Stall counter for the owning master's strobe; raises a
//               terminal pulse once TIMEOUT_CYCLES unacknowledged cycles
//               have elapsed. Built only when WB_ARB_TIMEOUT_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`ifdef WB_ARB_TIMEOUT_EN
module wb_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expire
);
    localparam int              c_CW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CW-1:0] c_TERM = c_CW'(TIMEOUT_CYCLES);

    logic [c_CW-1:0] r_count;

    // Count stalled strobe cycles, saturating at the terminal value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_en && (r_count != c_TERM)) begin
            r_count <= r_count + c_CW'(1);
        end
    end

    // Terminal pulse only while the stall is still live, so it lasts one cycle
    assign o_expire = i_count_en && (r_count == c_TERM);

endmodule : wb_arb_watchdog
`endif
`default_nettype wire

// File: rtl/wb_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_2to1
// Description : Round-robin 2-master / 1-slave classic Wishbone arbiter.
//               m0 = instruction master, m1 = data master. Grant is held for
//               the owner's whole cyc. Optional stall timeout with abort is
//               enabled by defining WB_ARB_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module wb_arbiter_2to1
    import wb_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // master 0 (instruction)
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    // master 1 (data)
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    // slave
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    input  logic                    s_ack_i
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last_grant;
    logic       w_last_grant_nxt;
    logic       w_m0_err;
    logic       w_m1_err;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("wb_arbiter_2to1: TIMEOUT_CYCLES must be >= 1");
    end

`ifdef WB_ARB_TIMEOUT_EN
    logic w_in_grant;
    logic w_releasing;
    logic w_owner_stb;
    logic w_count_en;
    logic w_wd_clear;
    logic w_expire;
    logic r_abort_owner;

    assign w_in_grant  = (r_state == GRANT0) || (r_state == GRANT1);
    assign w_releasing = ((r_state == GRANT0) && !m0_cyc_i) ||
                         ((r_state == GRANT1) && !m1_cyc_i);
    assign w_owner_stb = ((r_state == GRANT0) && m0_stb_i) ||
                         ((r_state == GRANT1) && m1_stb_i);
    assign w_count_en  = w_owner_stb && !s_ack_i && !w_releasing;
    // A direct handover also leaves the current grant, so the release clears too
    assign w_wd_clear  = !w_in_grant || s_ack_i || w_releasing;

    wb_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_wd_clear),
        .i_count_en (w_count_en),
        .o_expire   (w_expire)
    );

    // Remember which master timed out so its own cyc releases the abort
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_abort_owner <= 1'b0;
        end else if ((r_state != ABORT) && (w_state_nxt == ABORT)) begin
            r_abort_owner <= (r_state == GRANT1);
        end
    end

    assign w_m0_err = w_expire && (r_state == GRANT0);
    assign w_m1_err = w_expire && (r_state == GRANT1);
`else
    assign w_m0_err = 1'b0;
    assign w_m1_err = 1'b0;
`endif

    assign m0_err_o = w_m0_err;
    assign m1_err_o = w_m1_err;

    // State and round-robin pointer; m0 wins the first tie after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

    // Next-state: grant on request, hold while owner's cyc is high, hand over on release
    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_nxt = r_last_grant ? GRANT0 : GRANT1;
                end else if (m0_cyc_i) begin
                    w_state_nxt = GRANT0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = GRANT1;
                end
            end
            GRANT0: begin
                if (!m0_cyc_i) begin
                    w_last_grant_nxt = 1'b0;
                    w_state_nxt      = m1_cyc_i ? GRANT1 : IDLE;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (w_expire) begin
                    w_state_nxt = ABORT;
                end
`endif
            end
            GRANT1: begin
                if (!m1_cyc_i) begin
                    w_last_grant_nxt = 1'b1;
                    w_state_nxt      = m0_cyc_i ? GRANT0 : IDLE;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (w_expire) begin
                    w_state_nxt = ABORT;
                end
`endif
            end
            ABORT: begin
`ifdef WB_ARB_TIMEOUT_EN
                if (r_abort_owner ? !m1_cyc_i : !m0_cyc_i) begin
                    w_last_grant_nxt = r_abort_owner;
                    if (r_abort_owner) begin
                        w_state_nxt = m0_cyc_i ? GRANT0 : IDLE;
                    end else begin
                        w_state_nxt = m1_cyc_i ? GRANT1 : IDLE;
                    end
                end
`else
                w_state_nxt = IDLE;
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Output mux: owner's request to the slave, slave response to the owner only
    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        case (r_state)
            GRANT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
            end
            GRANT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
            end
`ifdef WB_ARB_TIMEOUT_EN
            ABORT: begin
                // Bus strobes are killed; late acks are swallowed
                s_we_o  = r_abort_owner ? m1_we_i  : m0_we_i;
                s_sel_o = r_abort_owner ? m1_sel_i : m0_sel_i;
                s_adr_o = r_abort_owner ? m1_adr_i : m0_adr_i;
                s_dat_o = r_abort_owner ? m1_dat_i : m0_dat_i;
            end
`endif
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
    end

endmodule : wb_arbiter_2to1
`default_nettype wire

// File: tb/tb_wb_arbiter_2to1.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter_2to1
// Description : Directed scoreboard bench for wb_arbiter_2to1. Expected beats
//               are queued by the stimulus; a monitor checks every ack.
//               Timeout scenario is selected by WB_ARB_TIMEOUT_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_wb_arbiter_2to1;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [SW-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
    logic          s_cyc_o, s_stb_o, s_we_o, s_ack_i;

    wb_arbiter_2to1 #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk      (clk),      .rst_n    (rst_n),
        .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
        .m0_sel_i (m0_sel_i), .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i),
        .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
        .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
        .m1_sel_i (m1_sel_i), .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i),
        .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
        .s_cyc_o  (s_cyc_o),  .s_stb_o  (s_stb_o),  .s_we_o   (s_we_o),
        .s_sel_o  (s_sel_o),  .s_adr_o  (s_adr_o),  .s_dat_o  (s_dat_o),
        .s_dat_i  (s_dat_i),  .s_ack_i  (s_ack_i)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic          m;
        logic [AW-1:0] adr;
        logic          we;
        logic [SW-1:0] sel;
        logic [DW-1:0] wdat;
        logic [DW-1:0] rdat;
    } exp_t;

    exp_t   sb_q[$];
    int     ack_cyc_q[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     cyc_n = 0;
    logic   slave_en = 1'b0;
    int     slave_wait = 0;
    logic   rd_ovr = 1'b0;
    logic [DW-1:0] rd_val = '0;
    localparam logic [DW-1:0] c_RD_XOR = 32'h5A5A_0000;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                           input logic [SW-1:0] sel, input logic [AW-1:0] adr,
                           input logic [DW-1:0] dat);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we;
            m0_sel_i = sel; m0_adr_i = adr; m0_dat_i = dat;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we;
            m1_sel_i = sel; m1_adr_i = adr; m1_dat_i = dat;
        end
    endtask

    // One bus cycle of 'beats' beats, then cyc low for exactly one cycle
    task automatic m_cycle(input int m, input logic [AW-1:0] adr0, input int beats,
                           input logic we, input logic [DW-1:0] wdat0);
        logic got;
        for (int b = 0; b < beats; b++) begin
            drive_m(m, 1'b1, 1'b1, we, 4'hF, adr0 + 32'(4 * b), we ? wdat0 + 32'(b) : '0);
            got = 1'b0;
            for (int t = 0; t < 200 && !got; t++) begin
                @(negedge clk);
                got = (m == 0) ? m0_ack_o : m1_ack_o;
                @(posedge clk);
                #1;
            end
            if (!got) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ack_wait m%0d: actual no ack in 200 cycles required ack", m);
            end
        end
        drive_m(m, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic m, input logic [AW-1:0] adr, input logic we,
                        input logic [DW-1:0] wdat, input logic [DW-1:0] rdat);
        sb_q.push_back('{m: m, adr: adr, we: we, sel: 4'hF, wdat: wdat, rdat: rdat});
    endtask

    initial forever begin
        @(posedge clk);
        cyc_n++;
    end

    // Slave model: ack after slave_wait wait states, ack never held two cycles
    initial begin
        int wcnt;
        wcnt    = 0;
        s_ack_i = 1'b0;
        s_dat_i = '0;
        forever begin
            @(posedge clk);
            #2;
            if (slave_en) begin
                if (s_ack_i) begin
                    s_ack_i = 1'b0;
                    wcnt    = 0;
                end else if (s_cyc_o && s_stb_o) begin
                    if (wcnt == slave_wait) begin
                        s_ack_i = 1'b1;
                        s_dat_i = rd_ovr ? rd_val : (s_adr_o ^ c_RD_XOR);
                    end else begin
                        wcnt++;
                    end
                end else begin
                    wcnt = 0;
                end
            end
        end
    end

    // Monitor: every master ack is matched against the next queued beat
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (m0_ack_o || m1_ack_o) begin
                ack_cyc_q.push_back(cyc_n);
                if (sb_q.size() == 0) begin
                    chk("unexpected_ack", {m0_ack_o, m1_ack_o}, 2'b00);
                end else begin
                    e = sb_q.pop_front();
                    chk("ack_owner", {m0_ack_o, m1_ack_o}, e.m ? 2'b01 : 2'b10);
                    chk("req_pass", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o},
                        {1'b1, 1'b1, e.we, e.sel, e.adr, e.wdat});
                    chk("rdata_route", e.m ? {m1_dat_o, m0_dat_o} : {m0_dat_o, m1_dat_o},
                        {e.rdat, 32'h0});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual still running required finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int err_cnt;
        int m1_err_cnt;
        int first_err;
        drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);

        // Reset held with both masters requesting
        drive_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h1111_0000);
        drive_m(1, 1'b1, 1'b1, 1'b1, 4'h3, 32'h0000_0200, 32'h2222_0000);
        repeat (2) @(posedge clk);
        s_dat_i = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("reset_ctrl", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, '0);
        chk("reset_bus", {s_adr_o, s_dat_o, m0_dat_o, m1_dat_o}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle_after_release", {s_cyc_o, s_stb_o}, 2'b00);
        @(negedge clk);
        chk("first_grant_m0", {s_cyc_o, s_stb_o, s_we_o, s_sel_o, s_adr_o, s_dat_o},
            {1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_0100, 32'h1111_0000});

        // Reset in the middle of the m0 transfer, with the slave acking
        #2;
        s_ack_i = 1'b1;
        rst_n   = 1'b0;
        #1;
        chk("reset_midxfer", {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o}, 4'b0000);
        s_ack_i = 1'b0;
        drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        drive_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stray ack in IDLE
        s_ack_i = 1'b1;
        s_dat_i = 32'hCAFE_F00D;
        @(negedge clk);
        chk("stray_ack", {m0_ack_o, m1_ack_o, s_cyc_o, m0_dat_o, m1_dat_o}, '0);
        @(posedge clk);
        #1 s_ack_i = 1'b0;
        @(negedge clk);
        chk("stray_ack_idle", {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o}, 4'b0000);

        // Tie alternation: m0, m1, m0, m1 with no idle cycle between owners
        slave_en   = 1'b1;
        slave_wait = 0;
        @(posedge clk);
        #1;
        push(1'b0, 32'h0000_1000, 1'b0, 32'h0, 32'h5A5A_1000);
        push(1'b1, 32'h0000_2000, 1'b1, 32'hA000_0001, 32'h5A5A_2000);
        push(1'b0, 32'h0000_1010, 1'b0, 32'h0, 32'h5A5A_1010);
        push(1'b1, 32'h0000_2010, 1'b1, 32'hA000_0002, 32'h5A5A_2010);
        ack_cyc_q.delete();
        t0 = cyc_n;
        fork
            begin
                m_cycle(0, 32'h0000_1000, 1, 1'b0, '0);
                m_cycle(0, 32'h0000_1010, 1, 1'b0, '0);
            end
            begin
                m_cycle(1, 32'h0000_2000, 1, 1'b1, 32'hA000_0001);
                m_cycle(1, 32'h0000_2010, 1, 1'b1, 32'hA000_0002);
            end
        join
        if (ack_cyc_q.size() != 4) begin
            chk("tie_ack_count", ack_cyc_q.size(), 4);
        end else begin
            chk("tie_ack_cycles", {8'(ack_cyc_q[0] - t0), 8'(ack_cyc_q[1] - t0),
                                   8'(ack_cyc_q[2] - t0), 8'(ack_cyc_q[3] - t0)},
                {8'd1, 8'd3, 8'd5, 8'd7});
        end

        // Lock: m1 holds 4 beats while m0 waits, then m0 right after release
        slave_wait = 2;
        push(1'b1, 32'h0000_3000, 1'b0, 32'h0, 32'h5A5A_3000);
        push(1'b1, 32'h0000_3004, 1'b0, 32'h0, 32'h5A5A_3004);
        push(1'b1, 32'h0000_3008, 1'b0, 32'h0, 32'h5A5A_3008);
        push(1'b1, 32'h0000_300C, 1'b0, 32'h0, 32'h5A5A_300C);
        push(1'b0, 32'h0000_4000, 1'b0, 32'h0, 32'h5A5A_4000);
        ack_cyc_q.delete();
        fork
            m_cycle(1, 32'h0000_3000, 4, 1'b0, '0);
            begin
                @(posedge clk);
                #1;
                m_cycle(0, 32'h0000_4000, 1, 1'b0, '0);
            end
        join
        if (ack_cyc_q.size() != 5) begin
            chk("lock_ack_count", ack_cyc_q.size(), 5);
        end else begin
            chk("lock_handover_gap", ack_cyc_q[4] - ack_cyc_q[3], 4);
        end

        // Read data routing to m1, ack in the third bus cycle
        rd_ovr = 1'b1;
        rd_val = 32'hDEAD_BEEF;
        push(1'b1, 32'h0000_5000, 1'b0, 32'h0, 32'hDEAD_BEEF);
        ack_cyc_q.delete();
        t0 = cyc_n;
        m_cycle(1, 32'h0000_5000, 1, 1'b0, '0);
        if (ack_cyc_q.size() != 1) begin
            chk("read_ack_count", ack_cyc_q.size(), 1);
        end else begin
            chk("read_ack_cycle", ack_cyc_q[0] - t0, 3);
        end
        rd_ovr   = 1'b0;
        slave_en = 1'b0;
        s_ack_i  = 1'b0;
        @(posedge clk);
        #1;

        // Slave never acks
        err_cnt    = 0;
        m1_err_cnt = 0;
        first_err  = -1;
`ifdef WB_ARB_TIMEOUT_EN
        drive_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_6000, '0);
        drive_m(1, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_7000, '0);
        t0 = cyc_n;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (m0_err_o) begin
                err_cnt++;
                if (first_err < 0) first_err = cyc_n - t0;
            end
            if (m1_err_o) m1_err_cnt++;
        end
        chk("timeout_err_pulse", {8'(err_cnt), 8'(first_err), 8'(m1_err_cnt)}, {8'd1, 8'd9, 8'd0});
        chk("abort_bus", {s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o}, 4'b0000);
        @(posedge clk);
        #1 drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_handover_m1", {s_cyc_o, s_stb_o, s_adr_o}, {1'b1, 1'b1, 32'h0000_7000});
        @(posedge clk);
        #1 drive_m(1, 1'b0, 1'b0, 1'b0, '0, '0, '0);
`else
        drive_m(0, 1'b1, 1'b1, 1'b0, 4'hF, 32'h0000_6000, '0);
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (m0_err_o) err_cnt++;
            if (m1_err_o) m1_err_cnt++;
        end
        chk("no_timeout_err", {8'(err_cnt), 8'(m1_err_cnt)}, 16'h0);
        chk("wait_forever", {s_cyc_o, s_stb_o, s_adr_o}, {1'b1, 1'b1, 32'h0000_6000});
        @(posedge clk);
        #1 drive_m(0, 1'b0, 1'b0, 1'b0, '0, '0, '0);
`endif
        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_wb_arbiter_2to1
`default_nettype wire

// File: doc/wb_arbiter_2to1.md
# wb_arbiter_2to1

Two-master to one-slave Wishbone (classic, non-pipelined) arbiter. It shares a single memory port between the core's instruction and data masters when only one memory is attached to the Controller. It sits between the core and the Controller's `core_*` bus. Arbitration is round-robin, and the grant is locked for the full `cyc` of the owning master.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: address width, all masters and the slave.
- `DATA_WIDTH`, default 32: data width; select width is `DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, default 255: cycles of unacknowledged `stb` before abort. Used only with `WB_ARB_TIMEOUT_EN`. Must be ≥1.

Ports (N = 0, 1; `m0` is the instruction master, `m1` the data master):
- `clk`  in  1  single clock, all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `mN_cyc_i`  in  1  master N bus cycle / request.
- `mN_stb_i`  in  1  master N strobe.
- `mN_we_i`  in  1  master N write enable.
- `mN_sel_i`  in  DATA_WIDTH/8  master N byte selects.
- `mN_adr_i`  in  ADDR_WIDTH  master N address.
- `mN_dat_i`  in  DATA_WIDTH  master N write data.
- `mN_dat_o`  out  DATA_WIDTH  read data to master N.
- `mN_ack_o`  out  1  acknowledge to master N.
- `mN_err_o`  out  1  error/abort to master N; constant 0 without `WB_ARB_TIMEOUT_EN`.
- `s_cyc_o`, `s_stb_o`, `s_we_o`  out  1 each  slave control.
- `s_sel_o`  out  DATA_WIDTH/8  slave byte selects.
- `s_adr_o`  out  ADDR_WIDTH  slave address.
- `s_dat_o`  out  DATA_WIDTH  slave write data.
- `s_dat_i`  in  DATA_WIDTH  slave read data.
- `s_ack_i`  in  1  slave acknowledge.

## Operation
States: `IDLE`, `GRANT0`, `GRANT1`, `ABORT`. A registered `last_grant` bit holds the round-robin pointer.

- **IDLE**
  - Slave outputs are all 0.
  - One `mN_cyc_i` high → `GRANTN`.
  - Both high → grant the master that is not `last_grant`.
- **GRANTN**
  - Slave outputs are a combinational copy of master N's inputs.
  - `mN_ack_o = s_ack_i` and `mN_dat_o = s_dat_i`.
  - The other master's ack/err/dat are 0.
  - `mN_cyc_i` low → `GRANT(other)` if the other master's `cyc` is high, else `IDLE`. The transition sets `last_grant = N`.
  - The grant is never pre-empted while `mN_cyc_i` is high, including across multiple `stb` beats.
- **ABORT** (only with the macro)
  - Slave `cyc`/`stb` are forced to 0.
  - Stays in `ABORT` until the owning master drops `cyc`, then applies the same release rule as `GRANTN`.
- `s_ack_i` arriving in `IDLE` or `ABORT` is discarded and never routed to any master.
- No address decoding. The arbiter does not register or alter data; `sel`, `we`, `adr` and `dat` pass through untouched.

## Timing
- **Reset** (asynchronous, active-low):
  - State → `IDLE`, `last_grant` → 1 so `m0` wins the first tie, timeout counter → 0.
  - All outputs are 0 while `rst_n` is low.
  - Reset asserted mid-transfer drops `s_cyc_o` immediately; no ack is forwarded.
- **Grant latency:** request seen in `IDLE` at cycle n → `s_cyc_o`/`s_stb_o` high in cycle n+1.
- **Handover:** the owner drops `cyc` at cycle k while the other master is requesting → the other master drives the slave at cycle k+1. There is no `IDLE` bubble.
- **Ack path:** `s_ack_i` → `mN_ack_o` is combinational, zero latency.
- **Simultaneous release and request by the same master:** `cyc` low for one cycle releases the grant. A re-request competes under round-robin.

## Configuration
- **`WB_ARB_TIMEOUT_EN` defined:**
  - A counter increments each cycle in `GRANTN` with `s_stb_o` high and `s_ack_i` low, and clears on ack or on leaving `GRANTN`.
  - On reaching `TIMEOUT_CYCLES`, `mN_err_o` pulses high for exactly one cycle and the state moves to `ABORT` on the next edge.
  - Counter width is `$clog2(TIMEOUT_CYCLES+1)`.
- **Undefined:** no counter, no `ABORT` state, `mN_err_o` tied to 0. The arbiter waits on `s_ack_i` indefinitely.

## Structure
- Package `wb_arb_pkg` holds:
  - the `arb_state_t` enum (`IDLE`, `GRANT0`, `GRANT1`, `ABORT`);
  - the default width constants.
- Sub-module `wb_arb_watchdog` (counter plus terminal pulse) is instantiated only under `WB_ARB_TIMEOUT_EN`.
- The output mux and FSM stay in the top module.

## Test plan
- **Reset:** hold `rst_n`=0 with both `cyc`=1 → all outputs 0. Release → `m0` is granted the next cycle with `s_adr_o = m0_adr_i`.
- **Tie alternation:** both masters hold `cyc` and issue one beat each, then release and re-request → grant order is m0, m1, m0, m1, with zero idle cycles between handovers.
- **Lock:** `m1` owns the bus for 4 beats (slave ack after 2 wait states each) while `m0` requests → `m0_ack_o` stays 0 throughout. `m0` gets the bus the cycle after `m1_cyc_i` falls.
- **Read data routing:** `m1` reads with `s_dat_i` = 32'hDEADBEEF, ack in cycle 3 → `m1_dat_o` = DEADBEEF with `m1_ack_o` in the same cycle, and `m0_dat_o` = 0.
- **Stray ack:** `s_ack_i` pulsed while in `IDLE` → no `mN_ack_o` asserts and the state is unchanged.
- **Timeout** (macro on, `TIMEOUT_CYCLES`=8): `m0` strobes and the slave never acks → `m0_err_o` is high for exactly 1 cycle after 8 cycles, then `s_cyc_o`=0. `m1` is granted the cycle after `m0_cyc_i` drops.
